// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the serial shift-register master family.
package shiftreg_pkg;

  localparam int unsigned DATA_W = 8;
  // Bit counter runs 0..DATA_W, so it needs one bit more than a bit index.
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  bit_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  function automatic logic last_bit(input bit_cnt_t cnt);
    return cnt == bit_cnt_t'(DATA_W - 1);
  endfunction

endpackage

// File: rtl/shiftreg_master_if.sv
// Host handshake plus serial pins of the shift-register master.
interface shiftreg_master_if;
  import shiftreg_pkg::*;

  logic  start;
  data_t tx_data;
  logic  busy;
  logic  done;
  data_t rx_data;
  logic  sck;
  logic  ld;
  logic  mosi;
  logic  miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sck, ld, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sck, ld, mosi
  );

endinterface

// File: rtl/shiftreg_tick.sv
// Loadable phase timer: expire is high on the last cycle of each HALF_PERIOD-long phase.
module shiftreg_tick #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/shiftreg_master.sv
// Master for the 8-bit serial shift-register peripheral: load, then full-duplex
// MSB-first exchange over sck/mosi/miso, one transfer per accepted start.
module shiftreg_master
  import shiftreg_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input logic               clk,
  input logic               rst,
  shiftreg_master_if.master bus
);

  state_t   state;
  bit_cnt_t bit_cnt;
  data_t    tx_sr;
  data_t    rx_sr;
  data_t    rx_q;
  logic     sck_q, ld_q, mosi_q, busy_q, done_q;
  logic     restart, expire;

  shiftreg_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .expire  (expire)
  );

  // Timer reloads on acceptance and on every timed-phase boundary.
  always_comb begin
    restart = 1'b0;
    unique case (state)
      IDLE:                                  restart = bus.start;
      LOAD, PRIME, SETUP, SHIFT_LO, SHIFT_HI: restart = expire;
      default:                               restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      ld_q    <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          tx_sr   <= bus.tx_data;
          bit_cnt <= '0;
          busy_q  <= 1'b1;
          ld_q    <= 1'b1;
          state   <= LOAD;
        end
        LOAD: if (expire) begin
          sck_q <= 1'b1;
          state <= PRIME;
        end
        PRIME: if (expire) begin
          ld_q  <= 1'b0;
          state <= SETUP;
        end
        SETUP: if (expire) begin
          sck_q  <= 1'b0;
          mosi_q <= tx_sr[DATA_W-1];
          tx_sr  <= tx_sr << 1;
          state  <= SHIFT_LO;
        end
        SHIFT_LO: if (expire) begin
          rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
          sck_q <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: if (expire) begin
          sck_q   <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit(bit_cnt)) begin
            mosi_q <= 1'b0;
            rx_q   <= rx_sr;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            mosi_q <= tx_sr[DATA_W-1];
            tx_sr  <= tx_sr << 1;
            state  <= SHIFT_LO;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sck     = sck_q;
  assign bus.ld      = ld_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_shiftreg_master.sv
// Bench for shiftreg_master: two instances (HALF_PERIOD 2 and 1), each wired to a
// behavioural remote shift register, checked against an exchange/timing model.
module tb_shiftreg_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  shiftreg_master_if b0 ();
  shiftreg_master_if b1 ();

  shiftreg_master #(.HALF_PERIOD(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  shiftreg_master #(.HALF_PERIOD(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Remote register: async load while ld, shift in on sck rise, present MSB on sck fall.
  logic [7:0] rem0_din = 8'h00, rem0_reg = 8'h00, rem1_din = 8'h00, rem1_reg = 8'h00;
  logic       rem0_so = 1'b0, rem1_so = 1'b0;

  always @(posedge b0.sck or posedge b0.ld)
    if (b0.ld) rem0_reg <= rem0_din; else rem0_reg <= {rem0_reg[6:0], b0.mosi};
  always @(negedge b0.sck) rem0_so <= rem0_reg[7];
  assign b0.miso = rem0_so;

  always @(posedge b1.sck or posedge b1.ld)
    if (b1.ld) rem1_reg <= rem1_din; else rem1_reg <= {rem1_reg[6:0], b1.mosi};
  always @(negedge b1.sck) rem1_so <= rem1_reg[7];
  assign b1.miso = rem1_so;

  typedef struct packed {
    logic       sck, ld, mosi, busy, done;
    logic [7:0] rx;
  } snap_t;

  typedef struct {
    int         done_at, ld_first, ld_last, rises, bad_width, busy_gaps;
    logic [7:0] rx, rem;
  } obs_t;

  typedef struct {
    int         sel;
    logic [7:0] tx, din, exp_rx, exp_rem;
  } vec_t;

  function automatic int half(input int sel);
    return (sel != 0) ? 1 : 2;
  endfunction

  function automatic snap_t snap(input int sel);
    snap_t s;
    if (sel != 0) s = '{b1.sck, b1.ld, b1.mosi, b1.busy, b1.done, b1.rx_data};
    else          s = '{b0.sck, b0.ld, b0.mosi, b0.busy, b0.done, b0.rx_data};
    return s;
  endfunction

  // Reference: a full-duplex exchange swaps the two bytes.
  function automatic logic [15:0] exchange_model(input logic [7:0] tx, input logic [7:0] din);
    return {din, tx};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] tx);
    if (sel != 0) begin b1.start = st; b1.tx_data = tx; end
    else          begin b0.start = st; b0.tx_data = tx; end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel != 0) b1.start = st; else b0.start = st;
  endtask

  task automatic set_din(input int sel, input logic [7:0] d);
    if (sel != 0) rem1_din = d; else rem0_din = d;
  endtask

  // Samples each negedge until done or limit; cycle index c counts from acceptance edge.
  task automatic watch(input int sel, input int acc, input int limit, input int drop_at,
                       input int inj_at, input logic [7:0] inj_tx, input bit inj_pulse,
                       output obs_t o);
    snap_t s;
    logic  prev_sck;
    int    run, c;
    bit    armed, seen_busy, fin;
    o.done_at = -1; o.ld_first = -1; o.ld_last = -1;
    o.rises = 0; o.bad_width = 0; o.busy_gaps = 0; o.rx = 8'h00; o.rem = 8'h00;
    prev_sck = 1'b0; run = 0; armed = 1'b0; seen_busy = 1'b0; fin = 1'b0;
    for (int i = 0; i < limit && !fin; i++) begin
      @(negedge clk);
      c = cyc - acc;
      s = snap(sel);
      if (s.ld) begin
        if (o.ld_first < 0) o.ld_first = c;
        o.ld_last = c;
      end
      if (s.sck != prev_sck) begin
        if (armed && run != half(sel)) o.bad_width++;
        if (!s.sck && !s.ld) armed = 1'b1;
        if (s.sck && !s.ld) o.rises++;
        run = 1;
      end else begin
        run++;
      end
      prev_sck = s.sck;
      if (s.busy) seen_busy = 1'b1;
      else if (seen_busy) o.busy_gaps++;
      if (s.done) begin
        o.done_at = c;
        o.rx      = s.rx;
        o.rem     = (sel != 0) ? rem1_reg : rem0_reg;
        fin       = 1'b1;
      end
      if (c == inj_at) drive(sel, 1'b1, inj_tx);
      if (c == drop_at || (inj_pulse && c == inj_at + 1)) set_start(sel, 1'b0);
    end
  endtask

  task automatic xfer(input int sel, input logic [7:0] tx, input logic [7:0] din,
                      input logic [7:0] exp_rx, input logic [7:0] exp_rem,
                      input int inj_at, input string tag);
    obs_t  o;
    snap_t s;
    int    acc, extra, h;
    h = half(sel);
    set_din(sel, din);
    @(negedge clk);
    drive(sel, 1'b1, tx);
    acc = cyc;
    watch(sel, acc, 19 * h + 20, 1, inj_at, 8'hFF, 1'b1, o);
    check({tag, "_done_cycle"}, o.done_at, 19 * h + 1);
    check({tag, "_rx_data"},    int'(o.rx), int'(exp_rx));
    check({tag, "_remote"},     int'(o.rem), int'(exp_rem));
    check({tag, "_sck_rises"},  o.rises, 8);
    check({tag, "_ld_first"},   o.ld_first, 1);
    check({tag, "_ld_last"},    o.ld_last, 2 * h);
    check({tag, "_sck_width"},  o.bad_width, 0);
    check({tag, "_busy_gap"},   o.busy_gaps, 0);
    extra = 0;
    repeat (38 * h) begin
      @(negedge clk);
      s = snap(sel);
      if (s.done || s.busy || s.sck || s.ld) extra++;
    end
    check({tag, "_idle_after"}, extra, 0);
  endtask

  initial begin
    vec_t       vecs[6];
    obs_t       o;
    snap_t      s;
    int         acc, bad, sel;
    logic [7:0] tx, din;
    logic [15:0] m;

    vecs[0] = '{sel: 0, tx: 8'h3C, din: 8'hA5, exp_rx: 8'hA5, exp_rem: 8'h3C};
    vecs[1] = '{sel: 1, tx: 8'h00, din: 8'hFF, exp_rx: 8'hFF, exp_rem: 8'h00};
    vecs[2] = '{sel: 0, tx: 8'hFF, din: 8'h00, exp_rx: 8'h00, exp_rem: 8'hFF};
    vecs[3] = '{sel: 1, tx: 8'hA5, din: 8'h5A, exp_rx: 8'h5A, exp_rem: 8'hA5};
    vecs[4] = '{sel: 0, tx: 8'h80, din: 8'h01, exp_rx: 8'h01, exp_rem: 8'h80};
    vecs[5] = '{sel: 1, tx: 8'h01, din: 8'h80, exp_rx: 8'h80, exp_rem: 8'h01};

    // Reset held with start high: nothing may move.
    rst = 1'b1;
    drive(0, 1'b1, 8'h5A);
    drive(1, 1'b1, 8'h5A);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        s = snap(k);
        if (s.busy || s.sck || s.ld || s.done || s.mosi) bad++;
      end
    end
    check("rst_hold_idle", bad, 0);
    s = snap(0);
    check("rst_sck",  int'(s.sck), 0);
    check("rst_ld",   int'(s.ld), 0);
    check("rst_mosi", int'(s.mosi), 0);
    check("rst_busy", int'(s.busy), 0);
    check("rst_done", int'(s.done), 0);
    check("rst_rx",   int'(s.rx), 0);
    s = snap(1);
    check("rst_dut1", int'({s.sck, s.ld, s.mosi, s.busy, s.done, s.rx}), 0);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst = 1'b0;

    foreach (vecs[i])
      xfer(vecs[i].sel, vecs[i].tx, vecs[i].din, vecs[i].exp_rx, vecs[i].exp_rem, -1, "vec");

    xfer(0, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 10, "ignored_start");

    // Back-to-back with start held; tx changed after first acceptance.
    set_din(0, 8'h55);
    @(negedge clk);
    drive(0, 1'b1, 8'h01);
    acc = cyc;
    watch(0, acc, 60, -1, 5, 8'h80, 1'b0, o);
    check("b2b_done1", o.done_at, 39);
    check("b2b_rx1",   int'(o.rx), 8'h55);
    check("b2b_rem1",  int'(o.rem), 8'h01);
    set_din(0, 8'hAA);
    watch(0, acc, 60, 41, -1, 8'h00, 1'b0, o);
    check("b2b_done2", o.done_at, 79);
    check("b2b_rx2",   int'(o.rx), 8'hAA);
    check("b2b_rem2",  int'(o.rem), 8'h80);
    repeat (10) @(negedge clk);

    // Reset during the shift phase.
    set_din(0, 8'h5A);
    @(negedge clk);
    drive(0, 1'b1, 8'hC3);
    acc = cyc;
    watch(0, acc, 19, 1, -1, 8'h00, 1'b0, o);
    check("mid_rst_no_early_done", o.done_at, -1);
    rst = 1'b1;
    @(negedge clk);
    s = snap(0);
    check("mid_rst_idle", int'({s.sck, s.ld, s.mosi, s.busy, s.done}), 0);
    check("mid_rst_rx",   int'(s.rx), 0);
    rst = 1'b0;
    xfer(0, 8'h96, 8'h69, 8'h69, 8'h96, -1, "post_rst");

    for (int n = 0; n < 10; n++) begin
      sel = int'($urandom_range(0, 1));
      tx  = 8'($urandom);
      din = 8'($urandom);
      m   = exchange_model(tx, din);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(sel, tx, din, m[15:8], m[7:0], -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
